// File: rtl/m_axi_mem_pkg.sv
// rtl/m_axi_mem_pkg.sv - shared helpers for the m_axi buffer-RAM FIFO controller
// Purpose: pointer wrap increment, counter width helper and default output-buffer depth.
// Ports: none (package).
`timescale 1ns/1ps
package m_axi_mem_pkg;

   localparam int OBUF_DEPTH_DEFAULT = 4;

   // Bits needed to hold any value in 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Increment that wraps to 0 after reaching limit (limit is the last valid index).
   function automatic int ptr_wrap_inc(input int ptr, input int limit);
      return (ptr >= limit) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/m_axi_mem_obuf.sv
// rtl/m_axi_mem_obuf.sv - register-based first-word-fall-through output buffer
// Purpose: small FIFO that holds words returning from the RAM read pipeline; the
//          head is presented combinationally so the consumer sees FWFT data.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   push_i         push push_data_i at the end of the cycle
//   push_data_i    data to push
//   pop_i          pop the head (ignored while empty)
//   count_o        current occupancy, 0..DEPTH
//   empty_n_o      occupancy is non-zero
//   head_o         head entry, zero while empty
`timescale 1ns/1ps
module m_axi_mem_obuf
   import m_axi_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = OBUF_DEPTH_DEFAULT,
   parameter int CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [CNT_W-1:0]      count_o,
   output logic                  empty_n_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   localparam int PTR_W = cnt_width(DEPTH - 1);

   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  pop_eff;

   always_comb begin
      pop_eff  = pop_i & (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = PTR_W'(ptr_wrap_inc(int'(wr_ptr_q), DEPTH - 1));
      end
      if (pop_eff) begin
         rd_ptr_d = PTR_W'(ptr_wrap_inc(int'(rd_ptr_q), DEPTH - 1));
      end
      if (push_i && !pop_eff) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_i && pop_eff) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

   assign count_o   = count_q;
   assign empty_n_o = (count_q != '0);
   // Zero while empty so nothing stale is ever visible on the output.
   assign head_o    = empty_n_o ? data_q[rd_ptr_q] : '0;

   // The controller's credit rule reserves a slot for every read in flight.
   a_obuf_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/m_axi_mem_fifo_ctrl.sv
// rtl/m_axi_mem_fifo_ctrl.sv - FIFO controller around an external 2-cycle-read buffer RAM
// Purpose: owns write/read pointers, RAM occupancy and read-issue timing, and
//          feeds a small FWFT output buffer so the consumer gets full-rate data
//          despite the RAM's registered address and registered dout.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   if_full_n/if_write/if_din  producer side (write accepted when both high)
//   if_empty_n/if_read/if_dout consumer side, FWFT head on if_dout
//   mem_clk_en                 RAM clock enable, tied high
//   mem_we/mem_waddr/mem_din   RAM write port
//   mem_raddr/mem_re           RAM read address (sampled every cycle) and dout-register enable
//   mem_dout                   RAM read data, valid two cycles after the issue cycle
`timescale 1ns/1ps
module m_axi_mem_fifo_ctrl
   import m_axi_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 63,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  mem_clk_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam int RAM_ENTRIES = DEPTH - 1;
   localparam int RC_W        = cnt_width(RAM_ENTRIES);
   localparam int OC_W        = cnt_width(OBUF_DEPTH);
   // Wide enough for obuf_count + inflight (up to OBUF_DEPTH + 2).
   localparam int CR_W        = OC_W + 1;

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [RC_W-1:0]       ram_count_q, ram_count_d;
   logic                  s1_valid_q, s2_valid_q;

   logic                  wr_acc;
   logic                  rd_issue;
   logic                  pop;
   logic [1:0]            inflight;
   logic [CR_W-1:0]       credit_used;
   logic [OC_W-1:0]       obuf_count;

   assign if_full_n = (ram_count_q < RC_W'(RAM_ENTRIES)) & ~reset;

   always_comb begin
      wr_acc      = if_write & if_full_n;
      inflight    = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
      credit_used = CR_W'(obuf_count) + CR_W'(inflight);
      // Only issue when the buffer is guaranteed a free slot for the returning
      // word. A word written this cycle is not yet counted, so it is never read
      // in the cycle the RAM is writing it.
      rd_issue    = (ram_count_q != '0) & (credit_used < CR_W'(OBUF_DEPTH));

      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      ram_count_d = ram_count_q;
      if (wr_acc) begin
         wptr_d = ADDR_WIDTH'(ptr_wrap_inc(int'(wptr_q), RAM_ENTRIES - 1));
      end
      if (rd_issue) begin
         rptr_d = ADDR_WIDTH'(ptr_wrap_inc(int'(rptr_q), RAM_ENTRIES - 1));
      end
      if (wr_acc && !rd_issue) begin
         ram_count_d = ram_count_q + RC_W'(1);
      end else if (!wr_acc && rd_issue) begin
         ram_count_d = ram_count_q - RC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_count_q <= '0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_count_q <= ram_count_d;
         // s1: RAM has latched the read address; s2: mem_dout holds the word.
         s1_valid_q  <= rd_issue;
         s2_valid_q  <= s1_valid_q;
      end
   end

   assign pop        = if_read & if_empty_n;

   assign mem_clk_en = 1'b1;
   assign mem_we     = wr_acc;
   assign mem_din    = if_din;
   assign mem_waddr  = reset ? '0 : wptr_q;
   // The RAM registers this address every cycle; only the issue cycle's value matters.
   assign mem_raddr  = reset ? '0 : rptr_q;
   assign mem_re     = s1_valid_q & ~reset;

   m_axi_mem_obuf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OBUF_DEPTH),
      .CNT_W      (OC_W)
   ) u_obuf (
      .clk         (clk),
      .reset       (reset),
      .push_i      (s2_valid_q),
      .push_data_i (mem_dout),
      .pop_i       (pop),
      .count_o     (obuf_count),
      .empty_n_o   (if_empty_n),
      .head_o      (if_dout)
   );

   a_ram_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(wr_acc && !rd_issue && (ram_count_q == RC_W'(RAM_ENTRIES))));
   a_ram_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(rd_issue && !wr_acc && (ram_count_q == '0)));

endmodule

// File: tb/tb_m_axi_mem_fifo_ctrl.sv
// tb/tb_m_axi_mem_fifo_ctrl.sv - self-checking bench for m_axi_mem_fifo_ctrl
`timescale 1ns/1ps
module tb_m_axi_mem_fifo_ctrl;

   localparam int DW      = 32;
   localparam int AW      = 6;
   localparam int DEPTH   = 63;
   localparam int OBUF    = 4;
   localparam int ENTRIES = DEPTH - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_full_n, if_write, if_empty_n, if_read;
   logic [DW-1:0] if_din, if_dout;
   logic          mem_clk_en, mem_we, mem_re;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic [DW-1:0] mem_din, mem_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   m_axi_mem_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .OBUF_DEPTH (OBUF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_full_n  (if_full_n),
      .if_write   (if_write),
      .if_din     (if_din),
      .if_empty_n (if_empty_n),
      .if_read    (if_read),
      .if_dout    (if_dout),
      .mem_clk_en (mem_clk_en),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_din    (mem_din),
      .mem_raddr  (mem_raddr),
      .mem_re     (mem_re),
      .mem_dout   (mem_dout)
   );

   // External RAM: registered read address, registered dout (enabled by mem_re).
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [AW-1:0] ram_addr_q = '0;
   logic [DW-1:0] ram_dout_q = '0;
   always @(posedge clk) begin
      if (mem_clk_en) begin
         if (mem_we) ram[mem_waddr] <= mem_din;
         ram_addr_q <= mem_raddr;
         if (mem_re) ram_dout_q <= ram[ram_addr_q];
      end
   end
   assign mem_dout = ram_dout_q;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: words in RAM, reads in flight with their stage, output buffer.
   typedef struct {
      logic [DW-1:0] data;
      int            stage;
   } pipe_t;

   logic [DW-1:0] m_ram[$];
   pipe_t         m_pipe[$];
   logic [DW-1:0] m_obuf[$];
   int            m_wcnt = 0;
   int            m_rcnt = 0;

   initial begin : model_check
      logic          e_full_n, e_wacc, e_issue, e_pop, e_empty_n, e_re;
      pipe_t         p;
      @(posedge clk);
      forever begin
         @(negedge clk);
         e_full_n  = !reset && (m_ram.size() < ENTRIES);
         e_wacc    = if_write && e_full_n;
         e_issue   = (m_ram.size() != 0) && (m_obuf.size() + m_pipe.size() < OBUF);
         e_empty_n = (m_obuf.size() != 0);
         e_pop     = if_read && e_empty_n;
         e_re      = 1'b0;
         foreach (m_pipe[k]) if (m_pipe[k].stage == 1) e_re = !reset;

         chk("cyc_if_full_n", if_full_n, e_full_n);
         chk("cyc_if_empty_n", if_empty_n, e_empty_n);
         if (e_empty_n) chk("cyc_if_dout", if_dout, m_obuf[0]);
         chk("cyc_mem_we", mem_we, e_wacc);
         chk("cyc_mem_waddr", mem_waddr, reset ? 0 : (m_wcnt % ENTRIES));
         chk("cyc_mem_raddr", mem_raddr, reset ? 0 : (m_rcnt % ENTRIES));
         chk("cyc_mem_re", mem_re, e_re);
         chk("cyc_mem_clk_en", mem_clk_en, 1);
         chk("cyc_ram_count", dut.ram_count_q, m_ram.size());

         if (reset) begin
            m_ram.delete();
            m_pipe.delete();
            m_obuf.delete();
            m_wcnt = 0;
            m_rcnt = 0;
         end else begin
            if (e_pop) void'(m_obuf.pop_front());
            if (m_pipe.size() != 0 && m_pipe[0].stage == 2) begin
               m_obuf.push_back(m_pipe[0].data);
               void'(m_pipe.pop_front());
            end
            foreach (m_pipe[k]) m_pipe[k].stage = 2;
            if (e_issue) begin
               p.data  = m_ram.pop_front();
               p.stage = 1;
               m_pipe.push_back(p);
               m_rcnt++;
            end
            if (e_wacc) begin
               m_ram.push_back(if_din);
               m_wcnt++;
            end
         end
      end
   end

   // Values sampled by the driver at the falling edge of each step.
   logic          l_acc, l_pop, l_full_n, l_empty_n;
   logic [DW-1:0] l_dout;
   int            l_rc;
   logic [1:0]    l_infl;

   task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
      if_write = w;
      if_din   = d;
      if_read  = r;
      @(negedge clk);
      l_full_n  = if_full_n;
      l_empty_n = if_empty_n;
      l_dout    = if_dout;
      l_acc     = w && if_full_n;
      l_pop     = r && if_empty_n;
      l_rc      = int'(dut.ram_count_q);
      l_infl    = {dut.s1_valid_q, dut.s2_valid_q};
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      int            acc, pops, first, lastc, maxrc;
      logic [DW-1:0] nxt;
      logic [DW-1:0] sb[$];
      logic          w, r;

      reset = 1'b1; if_write = 1'b0; if_read = 1'b0; if_din = '0;

      // Reset state
      step(0, 0, 0);
      step(0, 0, 0);
      chk("rst_full_n_low", l_full_n, 0);
      chk("rst_empty_n", l_empty_n, 0);
      chk("rst_dout", l_dout, 0);
      reset = 1'b0;
      step(0, 0, 0);
      chk("post_rst_full_n", l_full_n, 1);
      chk("post_rst_empty_n", l_empty_n, 0);
      chk("post_rst_dout", l_dout, 0);

      // Single word: write in cycle 0, visible in cycle 4
      step(1, 32'hA5A5_0001, 1);
      chk("sw_accept", l_acc, 1);
      for (int c = 1; c < 4; c++) begin
         step(0, 0, 1);
         chk("sw_not_yet", l_empty_n, 0);
      end
      step(0, 0, 1);
      chk("sw_empty_n", l_empty_n, 1);
      chk("sw_dout", l_dout, 32'hA5A5_0001);
      step(0, 0, 1);
      chk("sw_after_pop", l_empty_n, 0);

      // Streaming: one word per cycle once the pipeline has filled
      pops = 0; first = -1; lastc = -1; maxrc = 0;
      for (int c = 0; c < 510; c++) begin
         step(c < 500, DW'(1000 + c), 1);
         if (l_rc > maxrc) maxrc = l_rc;
         if (l_pop) begin
            chk("stream_data", l_dout, 1000 + pops);
            if (first < 0) first = c;
            lastc = c;
            pops++;
         end
      end
      chk("stream_first_pop", first, 4);
      chk("stream_pops", pops, 500);
      chk("stream_last_pop", lastc, 503);
      chk("stream_ramcnt_le3", maxrc <= 3, 1);

      // Fill with no reads: 62 in RAM + 4 in obuf
      acc = 0;
      for (int c = 0; c < 70; c++) begin
         step(1, DW'(c), 0);
         if (l_acc) acc++;
      end
      chk("fill_accepted", acc, 66);
      chk("fill_full_n", l_full_n, 0);
      chk("fill_ram_count", l_rc, 62);
      pops = 0;
      for (int c = 0; c < 300 && pops < 66; c++) begin
         step(0, 0, 1);
         if (l_pop) begin
            chk("drain_data", l_dout, pops);
            pops++;
         end
      end
      chk("drain_count", pops, 66);
      step(0, 0, 1);
      chk("drain_empty", l_empty_n, 0);

      // Random traffic with a scoreboard
      nxt = 32'h5000_0000; acc = 0;
      for (int c = 0; c < 20000 && acc < 2000; c++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         step(w, nxt, r);
         if (l_pop) begin
            chk("rand_sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk("rand_order", l_dout, sb.pop_front());
         end
         if (l_acc) begin
            sb.push_back(nxt);
            nxt++;
            acc++;
         end
      end
      for (int c = 0; c < 300 && sb.size() != 0; c++) begin
         step(0, 0, 1);
         if (l_pop) chk("rand_drain_order", l_dout, sb.pop_front());
      end
      chk("rand_accepted", acc, 2000);
      chk("rand_drained", sb.size(), 0);

      // Boundary: full RAM, obuf drains, issue frees a slot
      for (int c = 0; c < 70; c++) step(1, DW'(3000 + c), 0);
      chk("bnd_full", l_full_n, 0);
      step(0, 0, 1);
      chk("bnd_pop", l_pop, 1);
      step(0, 0, 1);
      chk("bnd_full_n_low", l_full_n, 0);
      chk("bnd_rc62", l_rc, 62);
      step(1, 32'hBEEF, 0);
      chk("bnd_full_n_freed", l_full_n, 1);
      chk("bnd_acc", l_acc, 1);
      chk("bnd_rc61", l_rc, 61);
      step(0, 0, 0);
      chk("bnd_rc_const", l_rc, 61);
      reset = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      reset = 1'b0;

      // Reset mid-stream with two reads in flight
      for (int c = 0; c < 12; c++) step(1, DW'(4000 + c), 0);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);
      reset = 1'b1;
      step(0, 0, 0);
      chk("mid_inflight", l_infl, 2'b11);
      chk("mid_rc_pre", l_rc, 6);
      chk("mid_empty_n_pre", l_empty_n, 1);
      reset = 1'b0;
      step(1, 32'h1234, 1);
      chk("mid_empty_after", l_empty_n, 0);
      chk("mid_full_n_after", l_full_n, 1);
      chk("mid_rc0", l_rc, 0);
      for (int c = 0; c < 3; c++) begin
         step(0, 0, 1);
         chk("mid_no_stale", l_empty_n, 0);
      end
      step(0, 0, 1);
      chk("mid_new_valid", l_empty_n, 1);
      chk("mid_new_data", l_dout, 32'h1234);
      step(0, 0, 0);
      chk("mid_final_empty", l_empty_n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
